// File: rtl/hadd_bist_if.sv
// Operand/response bundle between the BIST engine (master) and the half-adder datapath (slave).
interface hadd_bist_if #(
    parameter int WIDTH = 1
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;

    modport master (output a, output b, input sum, input carry);
    modport slave  (input a, input b, output sum, output carry);
endinterface

// File: rtl/hadd_bist.sv
// Exhaustive self-checking sweep of a WIDTH-bit parallel half adder with a configurable
// response latency; reports pass/fail, saturating error count and the first failing vector.
module hadd_bist #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    hadd_bist_if.master      dut_if,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [15:0]      err_count_o,
    output logic [WIDTH-1:0] fail_a_o,
    output logic [WIDTH-1:0] fail_b_o
);

    localparam int IDX_W = 2 * WIDTH + 1;
    localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [IDX_W-1:0] NUM_VEC  = IDX_W'(1) << (2 * WIDTH);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] failA_q, failA_d, failB_q, failB_d;
    logic [15:0]      errCount_q, errCount_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic             sampleNow;
    logic             mismatch;
    logic [IDX_W-1:0] idxNext;

    // The extra index bit lets the terminal count differ from vector 0.
    assign sampleNow = (lat_q == LAT_LAST);
    assign mismatch  = (dut_if.sum != (a_q ^ b_q)) || (dut_if.carry != (a_q & b_q));
    assign idxNext   = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            lat_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            failA_q    <= '0;
            failB_q    <= '0;
            errCount_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            a_q        <= a_d;
            b_q        <= b_d;
            failA_q    <= failA_d;
            failB_q    <= failB_d;
            errCount_q <= errCount_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        a_d        = a_q;
        b_d        = b_q;
        failA_d    = failA_q;
        failB_d    = failB_q;
        errCount_d = errCount_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = RUN;
                    idx_d      = '0;
                    lat_d      = '0;
                    a_d        = '0;
                    b_d        = '0;
                    failA_d    = '0;
                    failB_d    = '0;
                    errCount_d = '0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                if (sampleNow) begin
                    // First mismatch of the sweep is the one left in fail_a/fail_b.
                    if (mismatch) begin
                        if (errCount_q != 16'hFFFF) errCount_d = errCount_q + 16'd1;
                        if (errCount_q == 16'd0) begin
                            failA_d = a_q;
                            failB_d = b_q;
                        end
                    end
                    lat_d = '0;
                    idx_d = idxNext;
                    if (idxNext == NUM_VEC) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        a_d     = '0;
                        b_d     = '0;
                    end else begin
                        {a_d, b_d} = idxNext[2*WIDTH-1:0];
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                pass_d  = (errCount_q == 16'd0);
            end
            default: state_d = IDLE;
        endcase
    end

    assign dut_if.a    = a_q;
    assign dut_if.b    = b_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = errCount_q;
    assign fail_a_o    = failA_q;
    assign fail_b_o    = failB_q;

endmodule

// File: tb/tb_hadd_bist.sv
// Directed bench for hadd_bist: five engine instances, each paired with a good or faulty
// half-adder model, exercised one scenario at a time.
module tb_hadd_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0, start3 = 1'b0, start4 = 1'b0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hadd_bist_if #(.WIDTH(1)) if0 ();
    hadd_bist_if #(.WIDTH(1)) if1 ();
    hadd_bist_if #(.WIDTH(1)) if2 ();
    hadd_bist_if #(.WIDTH(1)) if3 ();
    hadd_bist_if #(.WIDTH(2)) if4 ();

    logic busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic busy3, done3, pass3, busy4, done4, pass4;
    logic [15:0] err0, err1, err2, err3, err4;
    logic failA0, failB0, failA1, failB1, failA2, failB2, failA3, failB3;
    logic [1:0] failA4, failB4;

    // Half-adder models: good, stuck-at-0 carry, 2-stage registered (two users), inverted sum.
    logic s2a, s2b, c2a, c2b, s3a, s3b, c3a, c3b;

    assign if0.sum   = if0.a ^ if0.b;
    assign if0.carry = if0.a & if0.b;
    assign if1.sum   = if1.a ^ if1.b;
    assign if1.carry = 1'b0;
    assign if2.sum   = s2b;
    assign if2.carry = c2b;
    assign if3.sum   = s3b;
    assign if3.carry = c3b;
    assign if4.sum   = ~(if4.a ^ if4.b);
    assign if4.carry = if4.a & if4.b;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2a <= 1'b0; s2b <= 1'b0; c2a <= 1'b0; c2b <= 1'b0;
            s3a <= 1'b0; s3b <= 1'b0; c3a <= 1'b0; c3b <= 1'b0;
        end else begin
            s2a <= if2.a ^ if2.b; s2b <= s2a; c2a <= if2.a & if2.b; c2b <= c2a;
            s3a <= if3.a ^ if3.b; s3b <= s3a; c3a <= if3.a & if3.b; c3b <= c3a;
        end
    end

    hadd_bist #(.WIDTH(1), .LATENCY(0)) u0 (.clk(clk), .rst(rst), .start_i(start0), .dut_if(if0),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_count_o(err0), .fail_a_o(failA0), .fail_b_o(failB0));
    hadd_bist #(.WIDTH(1), .LATENCY(0)) u1 (.clk(clk), .rst(rst), .start_i(start1), .dut_if(if1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1), .fail_a_o(failA1), .fail_b_o(failB1));
    hadd_bist #(.WIDTH(1), .LATENCY(2)) u2 (.clk(clk), .rst(rst), .start_i(start2), .dut_if(if2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2), .fail_a_o(failA2), .fail_b_o(failB2));
    hadd_bist #(.WIDTH(1), .LATENCY(0)) u3 (.clk(clk), .rst(rst), .start_i(start3), .dut_if(if3),
        .busy_o(busy3), .done_o(done3), .pass_o(pass3), .err_count_o(err3), .fail_a_o(failA3), .fail_b_o(failB3));
    hadd_bist #(.WIDTH(2), .LATENCY(0)) u4 (.clk(clk), .rst(rst), .start_i(start4), .dut_if(if4),
        .busy_o(busy4), .done_o(done4), .pass_o(pass4), .err_count_o(err4), .fail_a_o(failA4), .fail_b_o(failB4));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({if0.a, if0.b, busy0, done0, pass0} !== 5'b0) begin
            fails++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {if0.a, if0.b, busy0, done0, pass0});
        end
        checks++;
        if ({err0, failA0, failB0} !== 18'b0) begin
            fails++; $display("[TB] FAIL reset_status: got %h expected 0", {err0, failA0, failB0});
        end
        checks++;
        if ({if4.a, if4.b, err4, failA4, failB4, busy4} !== 25'b0) begin
            fails++; $display("[TB] FAIL reset_wide: got %h expected 0", {if4.a, if4.b, err4, failA4, failB4, busy4});
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({if0.a, if0.b, done0, busy0} !== 4'b0) begin
                fails++; $display("[TB] FAIL idle_quiet cycle %0d: got %b expected 0000", i, {if0.a, if0.b, done0, busy0});
            end
        end
    endtask

    task automatic test_clean_sweep;
        logic [1:0] expVec;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expVec = k[1:0];
            checks++;
            if ({if0.a, if0.b, busy0, done0} !== {expVec, 2'b10}) begin
                fails++; $display("[TB] FAIL clean_vec%0d: got %b expected %b", k, {if0.a, if0.b, busy0, done0}, {expVec, 2'b10});
            end
            tick();
        end
        checks++;
        if ({if0.a, if0.b, busy0, done0, err0} !== {4'b0001, 16'd0}) begin
            fails++; $display("[TB] FAIL clean_end: got %h expected %h", {if0.a, if0.b, busy0, done0, err0}, {4'b0001, 16'd0});
        end
        tick();
        checks++;
        if ({done0, pass0} !== 2'b01) begin
            fails++; $display("[TB] FAIL clean_pass: got %b expected 01", {done0, pass0});
        end
    endtask

    task automatic test_stuck_carry;
        int cnt = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        while (done1 !== 1'b1 && cnt < 50) begin tick(); cnt++; end
        checks++;
        if (cnt != 4) begin
            fails++; $display("[TB] FAIL stuck_done_time: got %0d expected 4", cnt);
        end
        checks++;
        if ({err1, failA1, failB1} !== {16'd1, 2'b11}) begin
            fails++; $display("[TB] FAIL stuck_result: got err=%0d fa=%b fb=%b expected err=1 fa=1 fb=1", err1, failA1, failB1);
        end
        tick();
        checks++;
        if (pass1 !== 1'b0) begin
            fails++; $display("[TB] FAIL stuck_pass: got %b expected 0", pass1);
        end
    endtask

    task automatic test_latency;
        int cnt = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        while (done2 !== 1'b1 && cnt < 50) begin tick(); cnt++; end
        checks++;
        if (cnt != 12) begin
            fails++; $display("[TB] FAIL lat2_done_time: got %0d expected 12", cnt);
        end
        checks++;
        if (err2 !== 16'd0) begin
            fails++; $display("[TB] FAIL lat2_err: got %0d expected 0", err2);
        end
        tick();
        checks++;
        if (pass2 !== 1'b1) begin
            fails++; $display("[TB] FAIL lat2_pass: got %b expected 1", pass2);
        end
        cnt = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        while (done3 !== 1'b1 && cnt < 50) begin tick(); cnt++; end
        checks++;
        if (cnt != 4 || err3 === 16'd0) begin
            fails++; $display("[TB] FAIL lat0_regdut: got time=%0d err=%0d expected time=4 err nonzero", cnt, err3);
        end
        tick();
        checks++;
        if (pass3 !== 1'b0) begin
            fails++; $display("[TB] FAIL lat0_pass: got %b expected 0", pass3);
        end
    endtask

    task automatic test_start_while_busy;
        logic [1:0] expVec;
        int doneSeen = 0;
        start0 = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            start0 = (k == 1);
            expVec = k[1:0];
            checks++;
            if ({if0.a, if0.b} !== expVec) begin
                fails++; $display("[TB] FAIL rebusy_vec%0d: got %b expected %b", k, {if0.a, if0.b}, expVec);
            end
            tick();
        end
        start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done0 === 1'b1) doneSeen++;
            tick();
        end
        checks++;
        if (doneSeen != 1) begin
            fails++; $display("[TB] FAIL rebusy_done_count: got %0d expected 1", doneSeen);
        end
    endtask

    task automatic test_back_to_back;
        int cnt = 0;
        int t1;
        start0 = 1'b1;
        tick();
        while (done0 !== 1'b1 && cnt < 50) begin tick(); cnt++; end
        t1 = cnt;
        tick(); cnt++;
        while (done0 !== 1'b1 && cnt < 50) begin tick(); cnt++; end
        start0 = 1'b0;
        checks++;
        if (t1 != 4 || cnt != 10) begin
            fails++; $display("[TB] FAIL b2b_done_times: got %0d,%0d expected 4,10", t1, cnt);
        end
        repeat (4) tick();
        checks++;
        if ({busy0, done0, pass0} !== 3'b001) begin
            fails++; $display("[TB] FAIL b2b_settle: got %b expected 001", {busy0, done0, pass0});
        end
    endtask

    task automatic test_reset_midsweep;
        int doneSeen = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (2) tick();
        checks++;
        if ({if0.a, if0.b, busy0} !== 3'b101) begin
            fails++; $display("[TB] FAIL abort_vec2: got %b expected 101", {if0.a, if0.b, busy0});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({if0.a, if0.b, busy0, done0, pass0, err0, failA0, failB0} !== 23'b0) begin
            fails++; $display("[TB] FAIL abort_outputs: got %h expected 0", {if0.a, if0.b, busy0, done0, pass0, err0, failA0, failB0});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done0 === 1'b1 || busy0 === 1'b1) doneSeen++;
        end
        checks++;
        if (doneSeen != 0) begin
            fails++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", doneSeen);
        end
    endtask

    task automatic test_wide;
        int cnt = 0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        while (done4 !== 1'b1 && cnt < 100) begin tick(); cnt++; end
        checks++;
        if (cnt != 16) begin
            fails++; $display("[TB] FAIL wide_done_time: got %0d expected 16", cnt);
        end
        checks++;
        if ({err4, failA4, failB4} !== {16'd16, 4'b0000}) begin
            fails++; $display("[TB] FAIL wide_result: got err=%0d fa=%0d fb=%0d expected err=16 fa=0 fb=0", err4, failA4, failB4);
        end
        tick();
        checks++;
        if ({if4.a, if4.b, pass4} !== 5'b0) begin
            fails++; $display("[TB] FAIL wide_pass: got %b expected 00000", {if4.a, if4.b, pass4});
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_stuck_carry();
        test_latency();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midsweep();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hadd_bist.md
# hadd_bist

Self-checking stimulus engine for the half-adder datapath (`hadd`), i.e. the initiator end of the `a`/`b`/`sum`/`carry` interface. On a `start` pulse it walks every `{a,b}` operand combination and drives it into the DUT. It samples the DUT's `sum`/`carry` after a configurable latency and compares them against the golden bitwise half-adder result. It then reports pass/fail, the error count and the first failing vector. It sits beside `hadd` in synthesizable self-test wrappers and replaces the hand-written stimulus sequence in benches.

## Interface
- `WIDTH`, default 1: operand width; the DUT is WIDTH parallel half adders.
- `LATENCY`, default 0: DUT response latency in clock cycles; 0 means combinational.
- `clk`  in  1  : single clock; all logic on the rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `start`  in  1  : begin a sweep; sampled only in IDLE.
- `a`  out  WIDTH  : registered operand A to the DUT.
- `b`  out  WIDTH  : registered operand B to the DUT.
- `sum`  in  WIDTH  : DUT sum response.
- `carry`  in  WIDTH  : DUT carry response.
- `busy`  out  1  : high while a sweep is in progress.
- `done`  out  1  : one-cycle pulse at the end of a sweep.
- `pass`  out  1  : 1 when the last completed sweep had zero errors.
- `err_count`  out  16  : mismatching vectors in the current or last sweep; saturates at 16'hFFFF.
- `fail_a`, `fail_b`  out  WIDTH each  : operands of the first mismatching vector.

## Operation
- FSM states:
  - IDLE: `start`=1 goes to RUN.
  - RUN: after the last vector's compare, goes to DONE.
  - DONE: goes to IDLE after exactly 1 cycle.
- Vector index `k` runs from 0 to N-1, where N = 2^(2·WIDTH). The driven value is `{a,b}` = k, with `b` in the low bits. For WIDTH=1 the order is (0,0), (0,1), (1,0), (1,1).
- Golden response for each vector: `sum` = a ^ b and `carry` = a & b, bitwise.
- A vector mismatches if either `sum` or `carry` differs in any bit. Each mismatching vector increments `err_count` by exactly 1.
- On the first mismatch of a sweep, `fail_a`/`fail_b` capture that vector. They are not overwritten until the next sweep starts.
- On `start` accepted in IDLE:
  - `err_count`, `fail_a`, `fail_b` and `pass` clear to 0.
  - `busy` goes to 1.
- `pass` is updated in DONE to (`err_count`==0), including the final compare. It then holds until the next `start` or `rst`.
- `start` while `busy` or in DONE: ignored, with no restart and no queueing.
- Index wrap: the index counter is 2·WIDTH+1 bits so that the terminal vector is detected without aliasing to vector 0.
- After a sweep, `a` and `b` return to 0.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_a`=0, `fail_b`=0, state IDLE.
- Let edge 0 be the edge at which `start`=1 is sampled in IDLE.
- Vector k appears on `a`/`b` after edge k·(LATENCY+1).
- Its response is sampled at edge (k+1)·(LATENCY+1).
- The next vector is driven at the same edge as that sample, so each vector occupies LATENCY+1 cycles.
- At edge N·(LATENCY+1):
  - the final compare is done;
  - `busy` goes to 0 and `done` goes to 1;
  - `a` and `b` go to 0.
- At the following edge: `done` goes to 0 and `pass` becomes valid.
- Total sweep is N·(LATENCY+1) cycles from edge 0 to the rising of `done`.
- `rst` mid-sweep: at that edge the sweep is aborted and all outputs return to their reset values. No `done` is produced.
- `start` held high: one sweep per IDLE visit. A new sweep begins at the edge after DONE if `start` is still 1.

## Test plan
1. Reset check: assert `rst` for 2 cycles -> all outputs 0 and `busy`=0. Then hold `start`=0 for 5 cycles -> `a`/`b` stay 0 and `done` never pulses.
2. Clean sweep, WIDTH=1, LATENCY=0, correct combinational `hadd`; pulse `start` -> `a`/`b` step through 00, 01, 10, 11 on consecutive cycles, `busy` is high for 4 cycles, `done` pulses once, `pass`=1, `err_count`=0.
3. Stuck-carry fault: DUT with `carry` tied to 0 -> `err_count`=1, `fail_a`=1, `fail_b`=1, `pass`=0.
4. Latency: LATENCY=2 with a 2-stage registered `hadd` -> `done` pulses 12 cycles after `start`, `pass`=1. The same DUT with LATENCY=0 -> `err_count` is nonzero.
5. Control hazards:
   - `start` re-pulsed while `busy` -> the vector sequence is unchanged and there is a single `done`.
   - `rst` asserted at vector 2 -> all outputs return to 0 on the next edge and no `done` pulse occurs.
6. Wide sweep, WIDTH=2, DUT `sum` inverted -> 16 vectors, `err_count`=16, `fail_a`=0, `fail_b`=0, `pass`=0.
